// File: rtl/priority_enc_pkg.sv
// Shared types and defaults for the priority encoder slice.
// State encoding and default widths live here.
package priority_enc_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int CODE_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/priority_encoder_comb.sv
// Plain combinational priority encoder: highest set bit wins.
// Also flags whether any request and more than one request is set.
module priority_encoder_comb #(
  parameter int WIDTH  = 4,
  parameter int CODE_W = 2
) (
  input  logic [WIDTH-1:0]  req,
  output logic [CODE_W-1:0] idx,
  output logic              any,
  output logic              multi
);

  if (CODE_W != $clog2(WIDTH)) begin : g_bad_code_w
    $error("CODE_W must equal log2(WIDTH)");
  end
  if (WIDTH < 2 || WIDTH > 16 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("WIDTH must be a power of 2 in 2..16");
  end

  // Scan upward so the highest set line overwrites lower ones.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        multi = multi | any;
        any   = 1'b1;
        idx   = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_4x2_hs.sv
// Sequential priority encoder with valid/ack hold and release wait.
// Optional input synchronizer: define PRIORITY_ENC_SYNC_EN.
module priority_encoder_4x2_hs
  import priority_enc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [0:WIDTH-1]  D_n,
  input  logic              enable_n,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              multi,
  output logic              busy
);

  logic [0:WIDTH-1]  dn_eff;
  logic              en_eff;
  logic [WIDTH-1:0]  req;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_multi;
  state_t            state;

`ifdef PRIORITY_ENC_SYNC_EN
  logic [0:WIDTH-1] dn_s1;
  logic [0:WIDTH-1] dn_s2;
  logic             en_s1;
  logic             en_s2;

  // Two-flop synchronizer; resets to inactive (all ones).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dn_s1 <= '1;
      dn_s2 <= '1;
      en_s1 <= 1'b1;
      en_s2 <= 1'b1;
    end else begin
      dn_s1 <= D_n;
      dn_s2 <= dn_s1;
      en_s1 <= enable_n;
      en_s2 <= en_s1;
    end
  end

  assign dn_eff = dn_s2;
  assign en_eff = en_s2;
`else
  assign dn_eff = D_n;
  assign en_eff = enable_n;
`endif

  // Effective active-high requests, masked by enable.
  always_comb begin
    req = '0;
    for (int i = 0; i < WIDTH; i++) begin
      req[i] = ~dn_eff[i] & ~en_eff;
    end
  end

  priority_encoder_comb #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_enc (
    .req   (req),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Capture, hold until ack, then wait for the captured line to drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      code  <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enc_any) begin
            code  <= enc_idx;
            multi <= enc_multi;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!req[code]) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder_4x2_hs.sv
// Randomized scoreboard bench for priority_encoder_4x2_hs.
// Captures are predicted by a protocol-level model and popped by a monitor.
module tb_priority_encoder_4x2_hs;

`ifdef PRIORITY_ENC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock;
  logic       reset;
  logic [0:3] d_n;
  logic       en_n;
  logic       ack_i;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       busy;

  int total;
  int bad;

  logic [2:0] exp_q[$];

  logic       m_valid;
  logic       m_busy;
  logic [1:0] m_code;
  logic       m_multi;
  logic [0:3] h_dn[2];
  logic       h_en[2];
  logic       vprev;

  priority_encoder_4x2_hs dut (
    .clock    (clock),
    .reset    (reset),
    .D_n      (d_n),
    .enable_n (en_n),
    .ack      (ack_i),
    .code     (code),
    .valid    (valid),
    .multi    (multi),
    .busy     (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_code  = 2'd0;
    m_multi = 1'b0;
    h_dn[0] = 4'b1111;
    h_dn[1] = 4'b1111;
    h_en[0] = 1'b1;
    h_en[1] = 1'b1;
    exp_q.delete();
  endtask

  // Protocol-level view of one clock edge.
  task automatic model_edge();
    logic [0:3] ed;
    logic       ee;
    logic [3:0] rq;
    int         hi;
`ifdef PRIORITY_ENC_SYNC_EN
    ed = h_dn[1];
    ee = h_en[1];
    h_dn[1] = h_dn[0];
    h_en[1] = h_en[0];
    h_dn[0] = d_n;
    h_en[0] = en_n;
`else
    ed = d_n;
    ee = en_n;
`endif
    for (int i = 0; i < 4; i++) rq[i] = !ed[i] && !ee;
    if (!m_busy) begin
      if (rq != 4'd0) begin
        hi = 0;
        for (int i = 0; i < 4; i++) if (rq[i]) hi = i;
        m_code  = 2'(hi);
        m_multi = ($countones(rq) > 1);
        m_valid = 1'b1;
        m_busy  = 1'b1;
        exp_q.push_back({m_multi, m_code});
      end
    end else if (m_valid) begin
      if (ack_i) m_valid = 1'b0;
    end else if (!rq[m_code]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("valid", int'(valid), int'(m_valid));
    chk("busy", int'(busy), int'(m_busy));
    chk("code", int'(code), int'(m_code));
    chk("multi", int'(multi), int'(m_multi));
  endtask

  task automatic step(input logic [0:3] d, input logic e, input logic a);
    d_n   = d;
    en_n  = e;
    ack_i = a;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  // Scoreboard monitor: each rising valid must match the next prediction.
  always @(negedge clock) begin
    logic [2:0] e;
    if (valid && !vprev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%0d/%0d t=%0t", code, multi, $time);
      end else begin
        e = exp_q.pop_front();
        if ({multi, code} !== e) begin
          bad++;
          $display("FAIL sb_capture got=%0d/%0d exp=%0d/%0d",
                   code, multi, e[1:0], e[2]);
        end
      end
    end
    vprev = valid;
  end

  initial begin
    int lat;
    bit got;
    total = 0;
    bad   = 0;
    vprev = 1'b0;
    model_reset();
    reset = 1'b1;
    d_n   = 4'b0000;
    en_n  = 1'b0;
    ack_i = 1'b0;
    #2;
    chk("rst_code", int'(code), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    step(4'b0000, 1'b0, 1'b0);
`ifndef PRIORITY_ENC_SYNC_EN
    chk("first_code", int'(code), 3);
    chk("first_multi", int'(multi), 1);
    chk("first_valid", int'(valid), 1);
`endif
    repeat (4) step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    repeat (5) step(4'b1111, 1'b0, 1'b1);

    step(4'b1101, 1'b0, 1'b0);
`ifndef PRIORITY_ENC_SYNC_EN
    chk("l2_code", int'(code), 2);
    chk("l2_multi", int'(multi), 0);
`endif
    step(4'b1110, 1'b0, 1'b0);
`ifndef PRIORITY_ENC_SYNC_EN
    chk("l2_hold", int'(code), 2);
`endif
    repeat (3) step(4'b1101, 1'b0, 1'b0);
    step(4'b1101, 1'b0, 1'b1);
    repeat (3) step(4'b1101, 1'b0, 1'b0);
    repeat (4) step(4'b1111, 1'b0, 1'b0);
    chk("l2_idle", int'(busy), 0);

    repeat (6) step(4'b0110, 1'b0, 1'b1);
    repeat (6) step(4'b1110, 1'b0, 1'b1);
    repeat (4) step(4'b1111, 1'b0, 1'b1);

    repeat (6) step(4'b0000, 1'b1, 1'b0);
    chk("masked_valid", int'(valid), 0);
    repeat (4) step(4'b1011, 1'b0, 1'b0);
    repeat (3) step(4'b1011, 1'b1, 1'b0);
    chk("l1_hold_code", int'(code), 1);
    chk("l1_hold_valid", int'(valid), 1);
    repeat (4) step(4'b1011, 1'b1, 1'b1);
    chk("l1_released", int'(busy), 0);

    repeat (6) step(4'b1111, 1'b0, 1'b1);
    d_n   = 4'b1011;
    en_n  = 1'b0;
    ack_i = 1'b0;
    lat   = 0;
    got   = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all();
      lat++;
      if (valid) got = 1'b1;
    end
    chk("latency", lat, LAT);
    chk("lat_code", int'(code), 1);

    #2 reset = 1'b1;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_code", int'(code), 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      logic [0:3] d;
      d = d_n;
      if ($urandom_range(0, 3) == 0) d = 4'($urandom);
      step(d, ($urandom_range(0, 4) == 0), 1'($urandom));
    end
    repeat (8) step(4'b1111, 1'b0, 1'b1);
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
